cronometro_bcd_lap: RTL and testbench
=====================================

// Module: cronometro_bcd_lap
// PURPOSE
//  Parametrised stopwatch, successor to the ms/s display stopwatch: counts MM:SS.mmm in cascaded BCD (no divide/modulo),
//  driven by a prescaled tick. Start/stop/clear via single-cycle command pulses; optional lap-freeze of the displayed time.
//  Feeds seven 7-segment digits on the board top level; command pulses come from the debounce/edge blocks.
// PARAMETERS
//  CLK_HZ          50_000_000  input clock frequency
//  TICK_HZ         1000        count resolution (1 ms); DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
//  MAX_MIN         59          last minute value before wrap (0..99)
//  SEG_ACTIVE_LOW  1           1: segment on = 0 (board default); 0: segment on = 1
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous, active-low reset
//  start_stop  in   1   1-cycle pulse: toggle run/pause
//  clear       in   1   1-cycle pulse: zero the time, go to IDLE
//  lap         in   1   1-cycle pulse: toggle display freeze (LAP_EN only)
//  running     out  1   1 while state == RUN
//  lap_hold    out  1   1 while the display is frozen
//  wrap        out  1   1-cycle pulse when MAX_MIN:59.999 rolls over to 00:00.000
//  ms_bcd      out  12  live milliseconds, 3 BCD digits {hundreds,tens,units}
//  sec_bcd     out  8   live seconds, 2 BCD digits
//  min_bcd     out  8   live minutes, 2 BCD digits
//  hex0..hex6  out  7   segments {g..a}: hex0 = ms units ... hex2 = ms hundreds, hex3/4 = sec, hex5/6 = min
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, prescaler 0, all BCD digits 0, running=0, lap_hold=0, wrap=0, hex* show "0".
//  FSM: IDLE -start_stop-> RUN; RUN -start_stop-> PAUSE; PAUSE -start_stop-> RUN; any state -clear-> IDLE.
//  clear has priority over start_stop and lap in the same cycle; clear zeroes digits and prescaler, releases lap_hold.
//  Prescaler counts 0..DIV-1 only in RUN; holds its value in PAUSE (resume keeps sub-ms phase).
//  tick = (prescaler == DIV-1) in RUN; digits update on the edge where tick is high.
//  Latency: start_stop accepted at edge N from IDLE -> ms units becomes 1 at edge N+DIV.
//  BCD cascade: each digit 0..9 (sec tens 0..5, min up to MAX_MIN); a carry increments the next digit in the same edge.
//  59.999 -> next minute; MAX_MIN:59.999 + tick -> 00:00.000, wrap=1 for exactly that cycle, counting continues.
//  Digits never hold a non-BCD value; outputs registered, hex* combinational from the display source.
//  Display source = live digits when lap_hold=0, lap register when lap_hold=1; ms/sec/min_bcd are always live.
//  start_stop while lap_hold=1: state changes, freeze stays. Reset mid-count: immediate return to reset values.
//  Segment map (active-high form, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; inverted if SEG_ACTIVE_LOW.
// CONFIGURATION
//  CRONO_LAP_EN defined: lap in RUN or PAUSE with lap_hold=0 copies live digits into the lap register
//    (value after any same-edge tick update), lap_hold=1; next lap releases (lap_hold=0). lap in IDLE ignored.
//  CRONO_LAP_EN undefined: lap input ignored, no lap register, lap_hold tied 0, display always live.
// TESTING (CLK_HZ=4000, TICK_HZ=1000 -> DIV=4, MAX_MIN=1, SEG_ACTIVE_LOW=1)
//  Reset then idle 20 cycles -> running=0, ms_bcd=000, hex0=7'b1000000, no change.
//  start_stop at edge 0 -> ms_bcd=001 at edge 4, 002 at edge 8; start_stop again at edge 10 -> ms holds 002;
//    resume at edge 20 -> 003 at edge 22 (phase kept).
//  Run 1000 ticks -> sec_bcd=01, ms_bcd=000 on the same edge; preload to 01:59.999 then one tick -> 00:00.000, wrap=1 one cycle.
//  clear and start_stop in the same cycle while RUN at 00:05.123 -> IDLE, all digits 0, running=0.
//  CRONO_LAP_EN: lap at 00:00.250 -> hex2..0 show 250 while ms_bcd advances; lap at 00:00.400 -> hex shows live 400.
//  Without CRONO_LAP_EN: lap pulses -> lap_hold stays 0, display tracks ms_bcd; rst_n low mid-run -> all outputs reset async.

Source files
------------

// File: rtl/cronometro_bcd_lap.sv
// cronometro_bcd_lap: MM:SS.mmm stopwatch counting in cascaded BCD from a
// prescaled tick, with start/stop/clear command pulses and seven 7-segment
// digit outputs. Optional lap freeze of the displayed time is built when the
// macro CRONO_LAP_EN is defined; without it the lap input is ignored and the
// display always shows the live time.
module cronometro_bcd_lap #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int MAX_MIN        = 59,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic        running,
    output logic        lap_hold,
    output logic        wrap,
    output logic [11:0] ms_bcd,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6
);

    // DIV must be an integer >= 2 (CLK_HZ a multiple of TICK_HZ).
    localparam int              DIV      = CLK_HZ / TICK_HZ;
    localparam int              PW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [7:0]      MIN_LAST = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [11:0]    ms_q, ms_d;
    logic [7:0]     sec_q, sec_d;
    logic [7:0]     min_q, min_d;
    logic           wrap_q, wrap_d;

    logic           tick;
    logic           c1, c2, c3, c4, c5;
    logic           min_max;

    logic [11:0]    disp_ms;
    logic [7:0]     disp_sec;
    logic [7:0]     disp_min;

    // One BCD digit step: advance when enabled, roll to 0 after 'last'.
    function automatic logic [3:0] dig_next(input logic [3:0] d,
                                            input logic [3:0] last,
                                            input logic       en);
        if (!en) return d;
        return (d == last) ? 4'd0 : d + 4'd1;
    endfunction

    // Segment pattern in {g..a} order, polarity set by SEG_ACTIVE_LOW.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] raw;
        case (d)
            4'd0:    raw = 7'h3F;
            4'd1:    raw = 7'h06;
            4'd2:    raw = 7'h5B;
            4'd3:    raw = 7'h4F;
            4'd4:    raw = 7'h66;
            4'd5:    raw = 7'h6D;
            4'd6:    raw = 7'h7D;
            4'd7:    raw = 7'h07;
            4'd8:    raw = 7'h7F;
            4'd9:    raw = 7'h6F;
            default: raw = 7'h00;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
    endfunction

    // Tick on the last prescaler count of a RUN cycle; carries ripple
    // combinationally so the whole cascade updates on the same edge.
    assign tick    = (state_q == ST_RUN) && (presc_q == PRE_LAST);
    assign c1      = tick && (ms_q[3:0]   == 4'd9);
    assign c2      = c1   && (ms_q[7:4]   == 4'd9);
    assign c3      = c2   && (ms_q[11:8]  == 4'd9);
    assign c4      = c3   && (sec_q[3:0]  == 4'd9);
    assign c5      = c4   && (sec_q[7:4]  == 4'd5);
    assign min_max = (min_q == MIN_LAST);

    // FSM next state: clear dominates, start_stop toggles run/pause.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler and BCD cascade next values; prescaler freezes outside RUN
    // so a resume keeps the sub-tick phase.
    always_comb begin
        presc_d = presc_q;
        ms_d    = {dig_next(ms_q[11:8], 4'd9, c2),
                   dig_next(ms_q[7:4],  4'd9, c1),
                   dig_next(ms_q[3:0],  4'd9, tick)};
        sec_d   = {dig_next(sec_q[7:4], 4'd5, c4),
                   dig_next(sec_q[3:0], 4'd9, c3)};
        min_d   = min_q;
        wrap_d  = 1'b0;
        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (c5) begin
            if (min_max) begin
                min_d  = 8'h00;
                wrap_d = 1'b1;
            end else begin
                min_d = {dig_next(min_q[7:4], 4'd9, min_q[3:0] == 4'd9),
                         dig_next(min_q[3:0], 4'd9, 1'b1)};
            end
        end
        if (clear) begin
            presc_d = '0;
            ms_d    = 12'h000;
            sec_d   = 8'h00;
            min_d   = 8'h00;
            wrap_d  = 1'b0;
        end
    end

    // State, prescaler, digits and wrap pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            ms_q    <= 12'h000;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef CRONO_LAP_EN
    logic        lap_hold_q, lap_hold_d;
    logic [27:0] lap_q, lap_d;

    // Lap toggles the freeze; capture takes the post-tick value of this edge.
    always_comb begin
        lap_hold_d = lap_hold_q;
        lap_d      = lap_q;
        if (clear) begin
            lap_hold_d = 1'b0;
        end else if (lap && (state_q != ST_IDLE)) begin
            if (!lap_hold_q) begin
                lap_d      = {min_d, sec_d, ms_d};
                lap_hold_d = 1'b1;
            end else begin
                lap_hold_d = 1'b0;
            end
        end
    end

    // Lap freeze flag and captured time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_hold_q <= 1'b0;
            lap_q      <= 28'h0;
        end else begin
            lap_hold_q <= lap_hold_d;
            lap_q      <= lap_d;
        end
    end

    assign lap_hold = lap_hold_q;
    assign {disp_min, disp_sec, disp_ms} = lap_hold_q ? lap_q : {min_q, sec_q, ms_q};
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_hold   = 1'b0;
    assign {disp_min, disp_sec, disp_ms} = {min_q, sec_q, ms_q};
`endif

    assign running = (state_q == ST_RUN);
    assign wrap    = wrap_q;
    assign ms_bcd  = ms_q;
    assign sec_bcd = sec_q;
    assign min_bcd = min_q;

    assign hex0 = seg7(disp_ms[3:0]);
    assign hex1 = seg7(disp_ms[7:4]);
    assign hex2 = seg7(disp_ms[11:8]);
    assign hex3 = seg7(disp_sec[3:0]);
    assign hex4 = seg7(disp_sec[7:4]);
    assign hex5 = seg7(disp_min[3:0]);
    assign hex6 = seg7(disp_min[7:4]);

endmodule

// File: tb/tb_cronometro_bcd_lap.sv
// Directed bench for cronometro_bcd_lap with DIV=4, MAX_MIN=1, active-low
// segments. Expected values are queued when stimulus is applied and popped
// when the corresponding output is sampled.
module tb_cronometro_bcd_lap;

    logic        clk = 1'b0;
    logic        rst_n, start_stop, clear, lap;
    logic        running, lap_hold, wrap;
    logic [11:0] ms_bcd;
    logic [7:0]  sec_bcd, min_bcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    cronometro_bcd_lap #(
        .CLK_HZ(4000), .TICK_HZ(1000), .MAX_MIN(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
        .running(running), .lap_hold(lap_hold), .wrap(wrap),
        .ms_bcd(ms_bcd), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segl(input int d);
        logic [6:0] raw;
        case (d)
            0: raw = 7'h3F; 1: raw = 7'h06; 2: raw = 7'h5B; 3: raw = 7'h4F;
            4: raw = 7'h66; 5: raw = 7'h6D; 6: raw = 7'h7D; 7: raw = 7'h07;
            8: raw = 7'h7F; 9: raw = 7'h6F; default: raw = 7'h00;
        endcase
        return ~raw;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; step(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1; step(1); clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; step(1); lap = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step(3);
        push("rst_running", 0); push("rst_ms", 0); push("rst_hex0", 7'h40);
        push("rst_lap_hold", 0); push("rst_wrap", 0);
        pop(running); pop(ms_bcd); pop(hex0); pop(lap_hold); pop(wrap);

        rst_n = 1'b1;
        step(20);
        push("idle_running", 0); push("idle_ms", 0); push("idle_time", 0);
        push("idle_hex0", 7'h40); push("idle_hex6", 7'h40);
        pop(running); pop(ms_bcd); pop({min_bcd, sec_bcd}); pop(hex0); pop(hex6);

        // start at edge 0
        pulse_ss();
        push("start_running", 1); pop(running);
        step(3);
        push("lat_edge3_ms", 12'h000); pop(ms_bcd);
        step(1);
        push("lat_edge4_ms", 12'h001); push("lat_edge4_hex0", segl(1));
        pop(ms_bcd); pop(hex0);
        step(4);
        push("edge8_ms", 12'h002); pop(ms_bcd);
        step(1);
        pulse_ss(); // edge 10
        push("pause_running", 0); push("pause_ms", 12'h002);
        pop(running); pop(ms_bcd);
        step(9);
        push("pause_hold_ms", 12'h002); pop(ms_bcd);
        pulse_ss(); // edge 20
        push("resume_running", 1); pop(running);
        step(1);
        push("resume_edge21_ms", 12'h002); pop(ms_bcd);
        step(1);
        push("resume_edge22_ms", 12'h003); push("resume_hex0", segl(3));
        pop(ms_bcd); pop(hex0);

        pulse_clr();
        push("clear_running", 0); push("clear_ms", 0); pop(running); pop(ms_bcd);

        // 1000 ticks -> one second
        pulse_ss();
        step(3999);
        push("edge3999_ms", 12'h999); push("edge3999_sec", 8'h00);
        pop(ms_bcd); pop(sec_bcd);
        step(1);
        push("sec_carry_sec", 8'h01); push("sec_carry_ms", 12'h000);
        push("sec_carry_hex", {segl(1), segl(0), segl(0), segl(0)});
        pop(sec_bcd); pop(ms_bcd); pop({hex3, hex2, hex1, hex0});
        step(16492);
        push("t5123_time", {8'h00, 8'h05, 12'h123});
        push("t5123_hex", {segl(0), segl(5), segl(1), segl(2), segl(3)});
        pop({min_bcd, sec_bcd, ms_bcd}); pop({hex4, hex3, hex2, hex1, hex0});

        // clear and start_stop together: clear wins
        clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
        push("clr_prio_running", 0); push("clr_prio_time", 0);
        pop(running); pop({min_bcd, sec_bcd, ms_bcd});
        step(8);
        push("clr_prio_stay_running", 0); push("clr_prio_stay_ms", 0);
        pop(running); pop(ms_bcd);

        // preload 01:59.999 in IDLE then one tick -> wrap
        force dut.ms_q = 12'h999; force dut.sec_q = 8'h59; force dut.min_q = 8'h01;
        step(1);
        release dut.ms_q; release dut.sec_q; release dut.min_q;
        step(1);
        pulse_ss();
        step(3);
        push("prewrap_time", {8'h01, 8'h59, 12'h999}); push("prewrap_wrap", 0);
        push("prewrap_hex65", {segl(0), segl(1)});
        pop({min_bcd, sec_bcd, ms_bcd}); pop(wrap); pop({hex6, hex5});
        step(1);
        push("wrap_time", 0); push("wrap_pulse", 1); push("wrap_running", 1);
        pop({min_bcd, sec_bcd, ms_bcd}); pop(wrap); pop(running);
        step(1);
        push("wrap_end", 0); pop(wrap);
        step(3);
        push("postwrap_ms", 12'h001); push("postwrap_wrap", 0);
        pop(ms_bcd); pop(wrap);

        // 00:59.999 -> 01:00.000, no wrap
        pulse_clr();
        force dut.ms_q = 12'h999; force dut.sec_q = 8'h59; force dut.min_q = 8'h00;
        step(1);
        release dut.ms_q; release dut.sec_q; release dut.min_q;
        step(1);
        pulse_ss();
        step(4);
        push("min_carry_time", {8'h01, 8'h00, 12'h000}); push("min_carry_wrap", 0);
        pop({min_bcd, sec_bcd, ms_bcd}); pop(wrap);

        // lap behaviour
        pulse_clr();
        pulse_lap();
        push("lap_idle_hold", 0); pop(lap_hold);
        pulse_ss();
        step(1001);
        pulse_lap(); // edge 1002, live 250
`ifdef CRONO_LAP_EN
        push("lap_hold_set", 1); push("lap_hex", {segl(2), segl(5), segl(0)});
        pop(lap_hold); pop({hex2, hex1, hex0});
        step(198);
        push("lap_live_ms", 12'h300); push("lap_frozen_hex", {segl(2), segl(5), segl(0)});
        push("lap_hold_kept", 1);
        pop(ms_bcd); pop({hex2, hex1, hex0}); pop(lap_hold);
        step(401);
        pulse_lap(); // edge 1602, live 400
        push("lap_release", 0); push("lap_release_hex", {segl(4), segl(0), segl(0)});
        pop(lap_hold); pop({hex2, hex1, hex0});
        step(2);
        push("lap_live_again", {segl(4), segl(0), segl(1)}); pop({hex2, hex1, hex0});
`else
        push("nolap_hold", 0); push("nolap_ms", 12'h250);
        push("nolap_hex", {segl(2), segl(5), segl(0)});
        pop(lap_hold); pop(ms_bcd); pop({hex2, hex1, hex0});
        step(4);
        push("nolap_track_hex0", segl(1)); push("nolap_hold_later", 0);
        pop(hex0); pop(lap_hold);
`endif

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #2;
        push("arst_running", 0); push("arst_time", 0); push("arst_wrap", 0);
        push("arst_lap_hold", 0); push("arst_hex", {segl(0), segl(0), segl(0)});
        pop(running); pop({min_bcd, sec_bcd, ms_bcd}); pop(wrap); pop(lap_hold);
        pop({hex2, hex1, hex0});
        step(2);
        rst_n = 1'b1;
        step(5);
        push("after_rst_running", 0); push("after_rst_ms", 0);
        pop(running); pop(ms_bcd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
